branch_predict_unit: RTL
========================

# branch_predict_unit

Parametrised branch prediction and resolution unit for the 5-stage RV32 pipeline. It replaces the purely combinational flag-based branch decision. The IF stage gets a bimodal direction prediction plus a target from a direct-mapped BTB. In EX, branches are resolved from the ALU flags, the prediction is checked, a registered flush/redirect is issued on a mispredict, and both predictor tables are trained.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- IDX_W, 6, table index bits; 2^IDX_W entries in both BHT and BTB
- CTR_INIT, 2'b01, reset value of every 2-bit counter (weakly not-taken)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- if_pc  in  XLEN  fetch PC
- pred_taken  out  1  predicted taken (combinational)
- pred_target  out  XLEN  predicted target (combinational)
- ex_valid  in  1  EX holds a live instruction
- ex_branch  in  1  conditional branch in EX
- ex_jump  in  1  JAL/JALR in EX
- ex_func3  in  3  branch condition
- cf, zf, vf, sf  in  1 each  ALU flags from rs1−rs2; cf=1 means no borrow
- ex_pc  in  XLEN  PC of EX instruction
- ex_target  in  XLEN  computed taken target
- ex_pred_taken  in  1  prediction carried from IF
- ex_pred_target  in  XLEN  target carried from IF
- ex_taken  out  1  resolved direction (combinational)
- flush  out  1  one-cycle mispredict pulse (registered)
- redirect_pc  out  XLEN  correct next PC (registered)
- br_count  out  32  resolved branches and jumps
- mis_count  out  32  mispredicts

## Operation
- Table addressing: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Each BTB entry holds {valid, tag, target}. Each BHT entry holds a 2-bit counter.
- Lookup: hit = valid[idx] & tag match. pred_taken = hit & ctr[idx][1]. pred_target = hit ? btb_target : if_pc+4.
- Condition evaluation by ex_func3:
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf≠vf
  - 101 BGE: sf==vf
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - other codes: not taken
- ex_taken = ex_jump | (ex_branch & condition).
- Resolution happens only when res = ex_valid & (ex_branch | ex_jump) & ~flush.
- Mispredict when res and either ex_taken≠ex_pred_taken, or ex_taken & ex_pred_target≠ex_target.
- Correct PC = ex_taken ? ex_target : ex_pc+4, computed modulo 2^XLEN.
- Training on res:
  - Conditional branch: saturating counter, +1 if taken, −1 if not; holds at 00 and 11.
  - Jump: counter is set to 11.
  - BTB: if taken, write {1, tag, ex_target}; a not-taken branch leaves the BTB unchanged.
- br_count increments on res; mis_count increments on mispredict. Both wrap at 2^32.

## Timing
- Reset values:
  - flush = 0, redirect_pc = 0
  - br_count and mis_count = 0
  - all BTB valid bits = 0
  - all counters = CTR_INIT
  - Reset takes effect at the next rising clk and overrides any simultaneous update.
- Prediction is zero-latency combinational from if_pc.
- Table writes take effect at the clock edge. A same-cycle lookup of the index being written returns the old contents.
- Mispredict detected in cycle N gives flush=1 and a valid redirect_pc in cycle N+1; flush returns to 0 in N+2.
- While flush=1, the EX instruction is wrong-path. It is ignored: no training, no counting, no new flush. This makes back-to-back flushes impossible.
- If the EX index equals an older valid entry with a different tag, the BTB entry is overwritten (replace on conflict).
- rst asserted mid-operation drops a pending flush; no redirect is issued.

## Configuration
- BPU_PERF_CNT_EN defined: br_count and mis_count are implemented as described.
- Not defined: both ports are tied to 0, the counter registers are removed, and prediction and resolution behaviour is unchanged.

## Structure
- Shared package (defines):
  - branch func3 codes BR_BEQ…BR_BGEU
  - counter encodings SNT=00, WNT=01, WT=10, ST=11
  - default IDX_W
- Sub-module branch_cond: the combinational func3/flag evaluator, instantiated once in EX.
- BHT and BTB are flop arrays; no RAM macro, so reset can clear them in one cycle.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104, flush=0, both counters 0.
- BEQ at 0x100, zf=1, ex_target=0x80, predicted not taken → cycle N+1 flush=1, redirect_pc=0x80; next lookup of 0x100 gives pred_taken=1 (counter 10), pred_target=0x80.
- Five taken BEQs at 0x100, then one not taken (zf=0) → counter saturates at 11, then 10; pred_taken stays 1; the last one flushes with redirect_pc=0x104.
- Each func3 with cf/zf/vf/sf sweeps: BLT sf=1 vf=0 → taken; BLTU cf=1 → not taken; func3=010 → never taken.
- Mispredict in cycle N, plus a second mispredicting branch with ex_valid=1 in N+1 → only one flush pulse; br_count advances by 1.
- Aliasing: JAL at 0x100 then JAL at 0x100+4·2^IDX_W with a different target → the second overwrites the BTB entry; lookup of 0x100 then misses (pred_target=0x104).

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit: branch condition codes,
// 2-bit counter encodings, default table size and the counter update helper.
package branch_predict_unit_pkg;

  localparam int IDX_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func3_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating 2-bit counter step: toward ST when taken, toward SNT otherwise.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != ST)
      res = ctr + 2'b01;
    else if (!taken && ctr != SNT)
      res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// Combinational branch condition evaluator: maps func3 and the rs1-rs2 ALU
// flags (cf=1 means no borrow) to a taken/not-taken decision.
module branch_cond
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       cf,
  input  logic       zf,
  input  logic       vf,
  input  logic       sf,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (func3)
      BR_BEQ:  cond = zf;
      BR_BNE:  cond = ~zf;
      BR_BLT:  cond = sf ^ vf;
      BR_BGE:  cond = ~(sf ^ vf);
      BR_BLTU: cond = ~cf;
      BR_BGEU: cond = cf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal BHT + direct-mapped BTB predictor with EX-stage resolution, registered
// flush/redirect and table training. Optional perf counters: BPU_PERF_CNT_EN.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = IDX_W_DEFAULT,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_func3,
  input  logic            cf,
  input  logic            zf,
  input  logic            vf,
  input  logic            sf,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mis_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;

  logic             btb_valid [ENTRIES];
  logic [TAG_W-1:0] btb_tag   [ENTRIES];
  logic [XLEN-1:0]  btb_tgt   [ENTRIES];
  logic [1:0]       bht_ctr   [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;
  logic             hit;
  logic             cond;
  logic             res;
  logic             mispredict;
  logic [XLEN-1:0]  correct_pc;
  logic             flush_reg;
  logic [XLEN-1:0]  redirect_pc_reg;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // IF lookup reads the flop arrays directly, so a write this cycle is not yet visible.
  assign hit         = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign pred_taken  = hit && bht_ctr[if_idx][1];
  assign pred_target = hit ? btb_tgt[if_idx] : (if_pc + XLEN'(4));

  branch_cond u_branch_cond (
    .func3 (ex_func3),
    .cf    (cf),
    .zf    (zf),
    .vf    (vf),
    .sf    (sf),
    .cond  (cond)
  );

  assign ex_taken   = ex_jump | (ex_branch & cond);
  // The instruction in EX during a flush cycle is wrong-path and must not resolve.
  assign res        = ex_valid & (ex_branch | ex_jump) & ~flush_reg;
  assign mispredict = res & ((ex_taken != ex_pred_taken) |
                             (ex_taken & (ex_pred_target != ex_target)));
  assign correct_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_tag[i]   <= '0;
        btb_tgt[i]   <= '0;
        bht_ctr[i]   <= CTR_INIT;
      end
    end else if (res) begin
      if (ex_jump)
        bht_ctr[ex_idx] <= ST;
      else
        bht_ctr[ex_idx] <= ctr_update(bht_ctr[ex_idx], ex_taken);
      if (ex_taken) begin
        btb_valid[ex_idx] <= 1'b1;
        btb_tag[ex_idx]   <= ex_tag;
        btb_tgt[ex_idx]   <= ex_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_reg       <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      flush_reg <= mispredict;
      if (mispredict)
        redirect_pc_reg <= correct_pc;
    end
  end

  assign flush       = flush_reg;
  assign redirect_pc = redirect_pc_reg;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] br_count_reg;
  logic [31:0] mis_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_reg  <= '0;
      mis_count_reg <= '0;
    end else begin
      if (res)
        br_count_reg <= br_count_reg + 32'd1;
      if (mispredict)
        mis_count_reg <= mis_count_reg + 32'd1;
    end
  end

  assign br_count  = br_count_reg;
  assign mis_count = mis_count_reg;
`else
  assign br_count  = '0;
  assign mis_count = '0;
`endif

endmodule
